// File: rtl/neuron_q_collector.sv
// Purpose: captures strobed neuron output samples Q into a show-ahead FIFO drained by valid/ready.
// Latency: a sample strobed on edge N is on OUT_DATA with OUT_VLD high right after edge N (empty FIFO).
// Backpressure: none upstream; when full, samples are dropped, counted in DROP_CNT and flagged by OVF.
//
// Ports:
//   CK, RSTN            clock, async active-low reset
//   Q, Q_VLD            neuron sample and its capture strobe
//   CLR                 synchronous clear of contents, OVF and DROP_CNT (beats push/pop/drop)
//   OUT_DATA/VLD/RDY    head-of-FIFO handshake towards the consumer
//   COUNT, FULL, EMPTY  registered occupancy status
//   OVF, DROP_CNT       sticky overflow flag and saturating drop counter
module neuron_q_collector #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     CK,
    input  logic                     RSTN,
    input  logic [WIDTH-1:0]         Q,
    input  logic                     Q_VLD,
    input  logic                     CLR,
    output logic [WIDTH-1:0]         OUT_DATA,
    output logic                     OUT_VLD,
    input  logic                     OUT_RDY,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     FULL,
    output logic                     EMPTY,
    output logic                     OVF,
    output logic [7:0]               DROP_CNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic pop;
    logic push;
    logic drop;

    // Handshake terms come only from registered state plus the strobes, so
    // OUT_VLD never depends on OUT_RDY.
    assign pop  = ~empty_q & OUT_RDY;
    // A full FIFO still takes a sample when the head leaves in the same cycle.
    assign push = Q_VLD & (~full_q | pop);
    assign drop = Q_VLD & full_q & ~pop;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        drop_cnt_d = drop_cnt_q;

        if (CLR) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            ovf_d      = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = Q;
                // DEPTH is a power of two, so natural overflow wraps the pointer.
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_cnt_q != 8'hFF) begin
                    drop_cnt_d = drop_cnt_q + 8'd1;
                end
            end
        end

        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Show-ahead head: storage is cleared on reset, so OUT_DATA reads 0 then.
    assign OUT_DATA = mem_q[rd_ptr_q];
    assign OUT_VLD  = ~empty_q;
    assign COUNT    = count_q;
    assign FULL     = full_q;
    assign EMPTY    = empty_q;
    assign OVF      = ovf_q;
    assign DROP_CNT = drop_cnt_q;

endmodule

// File: tb/tb_neuron_q_collector.sv
module tb_neuron_q_collector;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             CK = 1'b0;
    logic             RSTN = 1'b0;
    logic [WIDTH-1:0] Q = '0;
    logic             Q_VLD = 1'b0;
    logic             CLR = 1'b0;
    logic [WIDTH-1:0] OUT_DATA;
    logic             OUT_VLD;
    logic             OUT_RDY = 1'b0;
    logic [3:0]       COUNT;
    logic             FULL;
    logic             EMPTY;
    logic             OVF;
    logic [7:0]       DROP_CNT;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard: samples the FIFO should hold, oldest first, plus overflow model.
    logic [7:0] sb[$];
    bit         m_ovf = 1'b0;
    int         m_drop = 0;

    neuron_q_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CK(CK), .RSTN(RSTN), .Q(Q), .Q_VLD(Q_VLD), .CLR(CLR),
        .OUT_DATA(OUT_DATA), .OUT_VLD(OUT_VLD), .OUT_RDY(OUT_RDY),
        .COUNT(COUNT), .FULL(FULL), .EMPTY(EMPTY), .OVF(OVF), .DROP_CNT(DROP_CNT)
    );

    always #5 CK = ~CK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Drives one cycle (called at posedge+1), updates the scoreboard and reports
    // what the consumer observed on a pop together with the expected head value.
    task automatic drive(input bit vld, input logic [7:0] d, input bit rdy, input bit clr,
                         output bit popped, output logic [7:0] obs, output logic [7:0] exp);
        bit full;
        Q_VLD = vld; Q = d; OUT_RDY = rdy; CLR = clr;
        #1;
        popped = 1'b0;
        obs = OUT_DATA;
        exp = '0;
        if (clr) begin
            sb.delete();
            m_ovf = 1'b0;
            m_drop = 0;
        end else begin
            full = (sb.size() == DEPTH);
            if (rdy && sb.size() > 0) begin
                popped = 1'b1;
                exp = sb.pop_front();
            end
            if (vld) begin
                if (!full || popped) sb.push_back(d);
                else begin
                    m_ovf = 1'b1;
                    if (m_drop != 255) m_drop++;
                end
            end
        end
        @(posedge CK);
        #1;
        Q_VLD = 1'b0; CLR = 1'b0; OUT_RDY = 1'b0;
    endtask

    task automatic test_reset();
        bit p; logic [7:0] o, e;
        RSTN = 1'b0;
        repeat (3) @(posedge CK);
        #1;
        n_checks++;
        if (OUT_DATA !== 8'h00 || EMPTY !== 1'b1 || OUT_VLD !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hold: data=%h empty=%b vld=%b, want 00/1/0", OUT_DATA, EMPTY, OUT_VLD);
        end
        RSTN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h00, 1'b0, 1'b0, p, o, e);
            n_checks++;
            if (EMPTY !== 1'b1 || OUT_VLD !== 1'b0 || COUNT !== 4'd0 || OVF !== 1'b0 || DROP_CNT !== 8'd0) begin
                n_errors++;
                $display("FAIL reset_idle[%0d]: empty=%b vld=%b count=%0d ovf=%b drop=%0d, want 1/0/0/0/0",
                         i, EMPTY, OUT_VLD, COUNT, OVF, DROP_CNT);
            end
        end
    endtask

    task automatic test_single_capture();
        bit p; logic [7:0] o, e;
        drive(1'b1, 8'hA5, 1'b0, 1'b0, p, o, e);
        n_checks++;
        if (OUT_VLD !== 1'b1 || OUT_DATA !== 8'hA5 || COUNT !== 4'd1) begin
            n_errors++;
            $display("FAIL single_capture: vld=%b data=%h count=%0d, want 1/a5/1", OUT_VLD, OUT_DATA, COUNT);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0, p, o, e);
        n_checks++;
        if (!p || o !== e) begin
            n_errors++;
            $display("FAIL single_pop: popped=%b got %h want %h", p, o, e);
        end
        n_checks++;
        if (EMPTY !== 1'b1 || OUT_VLD !== 1'b0) begin
            n_errors++;
            $display("FAIL single_empty: empty=%b vld=%b, want 1/0", EMPTY, OUT_VLD);
        end
    endtask

    task automatic test_fill_overflow();
        bit p; logic [7:0] o, e;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 8'(i + 1), 1'b0, 1'b0, p, o, e);
            if (i == 7) begin
                n_checks++;
                if (FULL !== 1'b1 || COUNT !== 4'd8 || OVF !== 1'b0) begin
                    n_errors++;
                    $display("FAIL fill_full: full=%b count=%0d ovf=%b, want 1/8/0", FULL, COUNT, OVF);
                end
            end
        end
        n_checks++;
        if (OVF !== 1'b1 || DROP_CNT !== 8'd3 || DROP_CNT !== 8'(m_drop) || FULL !== 1'b1) begin
            n_errors++;
            $display("FAIL fill_overflow: ovf=%b drop=%0d full=%b, want 1/3/1", OVF, DROP_CNT, FULL);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, p, o, e);
            n_checks++;
            if (!p || o !== e || o !== 8'(i + 1)) begin
                n_errors++;
                $display("FAIL fill_drain[%0d]: got %h want %h", i, o, 8'(i + 1));
            end
        end
        n_checks++;
        if (EMPTY !== 1'b1 || COUNT !== 4'd0 || OVF !== 1'b1) begin
            n_errors++;
            $display("FAIL fill_drained: empty=%b count=%0d ovf=%b, want 1/0/1", EMPTY, COUNT, OVF);
        end
    endtask

    task automatic test_push_while_full();
        bit p; logic [7:0] o, e;
        drive(1'b0, 8'h00, 1'b0, 1'b1, p, o, e);
        n_checks++;
        if (OVF !== 1'b0 || DROP_CNT !== 8'd0) begin
            n_errors++;
            $display("FAIL pwf_clear: ovf=%b drop=%0d, want 0/0", OVF, DROP_CNT);
        end
        for (int i = 0; i < 8; i++) drive(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, p, o, e);
        drive(1'b1, 8'h18, 1'b1, 1'b0, p, o, e);
        n_checks++;
        if (!p || o !== e || o !== 8'h10) begin
            n_errors++;
            $display("FAIL pwf_pop: got %h want 10", o);
        end
        n_checks++;
        if (OUT_DATA !== 8'h11 || COUNT !== 4'd8 || FULL !== 1'b1 || OVF !== 1'b0 || DROP_CNT !== 8'd0) begin
            n_errors++;
            $display("FAIL pwf_state: data=%h count=%0d full=%b ovf=%b drop=%0d, want 11/8/1/0/0",
                     OUT_DATA, COUNT, FULL, OVF, DROP_CNT);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, p, o, e);
            n_checks++;
            if (!p || o !== e || o !== 8'(8'h11 + i)) begin
                n_errors++;
                $display("FAIL pwf_drain[%0d]: got %h want %h", i, o, 8'(8'h11 + i));
            end
        end
    endtask

    task automatic test_stream_wrap();
        bit p; logic [7:0] o, e, d;
        int errs_before = n_errors;
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom_range(0, 255));
            drive(1'b1, d, 1'b1, 1'b0, p, o, e);
            if (i > 0) begin
                n_checks++;
                if (!p || o !== e) begin
                    n_errors++;
                    $display("FAIL stream_pop[%0d]: popped=%b got %h want %h", i, p, o, e);
                end
            end
            n_checks++;
            if (OUT_VLD !== 1'b1 || OUT_DATA !== d || COUNT > 4'd1 || DROP_CNT !== 8'd0) begin
                n_errors++;
                $display("FAIL stream_cap[%0d]: vld=%b data=%h count=%0d drop=%0d, want 1/%h/<=1/0",
                         i, OUT_VLD, OUT_DATA, COUNT, DROP_CNT, d);
            end
            if (n_errors - errs_before > 4) break;
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0, p, o, e);
        n_checks++;
        if (!p || o !== e || EMPTY !== 1'b1 || OVF !== 1'b0) begin
            n_errors++;
            $display("FAIL stream_last: got %h want %h empty=%b ovf=%b", o, e, EMPTY, OVF);
        end
    endtask

    task automatic test_clear_and_reset();
        bit p; logic [7:0] o, e;
        for (int i = 0; i < 10; i++) drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, p, o, e);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1, 1'b0, p, o, e);
            n_checks++;
            if (!p || o !== e) begin
                n_errors++;
                $display("FAIL clr_pre_pop[%0d]: got %h want %h", i, o, e);
            end
        end
        n_checks++;
        if (COUNT !== 4'd5 || COUNT !== 4'(sb.size()) || DROP_CNT !== 8'd2 || OVF !== 1'b1) begin
            n_errors++;
            $display("FAIL clr_pre: count=%0d drop=%0d ovf=%b, want 5/2/1", COUNT, DROP_CNT, OVF);
        end
        drive(1'b1, 8'hEE, 1'b1, 1'b1, p, o, e);
        n_checks++;
        if (COUNT !== 4'd0 || EMPTY !== 1'b1 || OUT_VLD !== 1'b0 || OVF !== 1'b0 || DROP_CNT !== 8'd0) begin
            n_errors++;
            $display("FAIL clr_state: count=%0d empty=%b vld=%b ovf=%b drop=%0d, want 0/1/0/0/0",
                     COUNT, EMPTY, OUT_VLD, OVF, DROP_CNT);
        end
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, p, o, e);
        n_checks++;
        if (COUNT !== 4'd3 || OUT_DATA !== 8'h60) begin
            n_errors++;
            $display("FAIL refill: count=%0d data=%h, want 3/60", COUNT, OUT_DATA);
        end
        // Reset pulse between edges: outputs must drop without any clock edge.
        #2;
        RSTN = 1'b0;
        sb.delete(); m_ovf = 1'b0; m_drop = 0;
        #1;
        n_checks++;
        if (COUNT !== 4'd0 || EMPTY !== 1'b1 || FULL !== 1'b0 || OUT_VLD !== 1'b0 ||
            OVF !== 1'b0 || DROP_CNT !== 8'd0 || OUT_DATA !== 8'h00) begin
            n_errors++;
            $display("FAIL async_reset: count=%0d empty=%b full=%b vld=%b ovf=%b drop=%0d data=%h",
                     COUNT, EMPTY, FULL, OUT_VLD, OVF, DROP_CNT, OUT_DATA);
        end
        @(negedge CK);
        RSTN = 1'b1;
        @(posedge CK);
        #1;
        drive(1'b1, 8'h77, 1'b0, 1'b0, p, o, e);
        n_checks++;
        if (OUT_VLD !== 1'b1 || OUT_DATA !== 8'h77 || COUNT !== 4'd1) begin
            n_errors++;
            $display("FAIL post_reset_capture: vld=%b data=%h count=%0d, want 1/77/1", OUT_VLD, OUT_DATA, COUNT);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0, p, o, e);
        n_checks++;
        if (!p || o !== e || EMPTY !== 1'b1) begin
            n_errors++;
            $display("FAIL post_reset_pop: got %h want %h empty=%b", o, e, EMPTY);
        end
    endtask

    initial begin
        test_reset();
        test_single_capture();
        test_fill_overflow();
        test_push_while_full();
        test_stream_wrap();
        test_clear_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
